// File: rtl/branch_resolve_unit_if.sv
// Execute-stage request and registered result bundle for the branch resolve unit.
// The execute stage is the master; the resolve unit is the slave.
interface branch_resolve_unit_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_branch;
  logic            in_jal;
  logic            in_jalr;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [XLEN-1:0] in_imm;
  logic            in_pred_taken;
  logic            flush;

  logic            res_valid;
  logic            res_taken;
  logic [XLEN-1:0] res_target;
  logic [XLEN-1:0] res_link;
  logic            res_mispredict;
  logic            res_misaligned;
  logic            res_illegal;

  modport master (
    output in_valid, in_branch, in_jal, in_jalr, in_funct3, in_pc,
           in_rs1, in_rs2, in_imm, in_pred_taken, flush,
    input  res_valid, res_taken, res_target, res_link, res_mispredict,
           res_misaligned, res_illegal
  );

  modport slave (
    input  in_valid, in_branch, in_jal, in_jalr, in_funct3, in_pc,
           in_rs1, in_rs2, in_imm, in_pred_taken, flush,
    output res_valid, res_taken, res_target, res_link, res_mispredict,
           res_misaligned, res_illegal
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves RV64I conditional branches and JAL/JALR with one-cycle latency, owns the
// 2-bit branch-history table used by fetch, and keeps saturating statistics.
module branch_resolve_unit #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [XLEN-1:0]      lk_pc,
  output logic                 lk_pred_taken,
  branch_resolve_unit_if.slave bus,
  output logic [CNT_W-1:0]     stat_branches,
  output logic [CNT_W-1:0]     stat_mispredicts
);

  logic [1:0]       hist [DEPTH];
  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] up_idx;
  logic             accept;
  logic             illegal;
  logic             legal_branch;
  logic             cond;
  logic             taken;
  logic             mispredict;
  logic             counted;
  logic [XLEN-1:0]  jalr_sum;
  logic [XLEN-1:0]  target;
  logic             unused_pc_bits;

  assign lk_idx = lk_pc[IDX_W+1:2];
  assign up_idx = bus.in_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{lk_pc[XLEN-1:IDX_W+2], lk_pc[1:0],
                            bus.in_pc[XLEN-1:IDX_W+2], bus.in_pc[1:0]};

  // Reads the table before this cycle's update lands, so a same-index collision
  // naturally returns the pre-update counter.
  assign lk_pred_taken = hist[lk_idx][1];

  assign accept       = bus.in_valid & ~bus.flush;
  assign illegal      = bus.in_branch & (bus.in_funct3[2:1] == 2'b01);
  assign legal_branch = bus.in_branch & ~illegal;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    cond = 1'b0;
    case (bus.in_funct3)
      3'b000:  cond = (bus.in_rs1 == bus.in_rs2);
      3'b001:  cond = (bus.in_rs1 != bus.in_rs2);
      3'b100:  cond = ($signed(bus.in_rs1) <  $signed(bus.in_rs2));
      3'b101:  cond = ($signed(bus.in_rs1) >= $signed(bus.in_rs2));
      3'b110:  cond = (bus.in_rs1 <  bus.in_rs2);
      3'b111:  cond = (bus.in_rs1 >= bus.in_rs2);
      default: cond = 1'b0;
    endcase
  end

  assign taken    = bus.in_jal | bus.in_jalr | (legal_branch & cond);
  assign jalr_sum = bus.in_rs1 + bus.in_imm;
  assign target   = bus.in_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (bus.in_pc + bus.in_imm);

  // A request with no control-transfer type is never a misprediction.
  assign mispredict = (bus.in_branch | bus.in_jal | bus.in_jalr) & (taken ^ bus.in_pred_taken);

  // Illegal encodings still flag a misprediction but touch neither statistic.
  assign counted = accept & (legal_branch | bus.in_jal | bus.in_jalr);

  // NOTE: sequential state is updated only with non-blocking assignments so all
  // registers see the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.res_valid      <= 1'b0;
      bus.res_taken      <= 1'b0;
      bus.res_target     <= '0;
      bus.res_link       <= '0;
      bus.res_mispredict <= 1'b0;
      bus.res_misaligned <= 1'b0;
      bus.res_illegal    <= 1'b0;
      stat_branches      <= '0;
      stat_mispredicts   <= '0;
    end else begin
      bus.res_valid <= accept;
      if (accept) begin
        bus.res_taken      <= taken;
        bus.res_target     <= target;
        bus.res_link       <= bus.in_pc + XLEN'(4);
        bus.res_mispredict <= mispredict;
        bus.res_misaligned <= taken & target[1];
        bus.res_illegal    <= illegal;
      end
      if (counted && stat_branches != '1)
        stat_branches <= stat_branches + CNT_W'(1);
      if (counted && mispredict && stat_mispredicts != '1)
        stat_mispredicts <= stat_mispredicts + CNT_W'(1);
    end
  end

  // NOTE: the history table is deliberately reset entry-by-entry (weakly
  // not-taken), so it must be built from flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) hist[i] <= 2'b01;
    end else if (accept && legal_branch) begin
      if (cond && hist[up_idx] != 2'b11)
        hist[up_idx] <= hist[up_idx] + 2'd1;
      else if (!cond && hist[up_idx] != 2'b00)
        hist[up_idx] <= hist[up_idx] - 2'd1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized scoreboard bench for branch_resolve_unit: a driver predicts each result
// from a behavioural model and queues it; a monitor pops and compares on res_valid.
module tb_branch_resolve_unit;
  localparam int XLEN  = 64;
  localparam int DEPTH = 16;
  localparam int CNT_W = 6;
  localparam longint CMAX = (64'd1 << CNT_W) - 1;

  typedef struct {
    logic            taken;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link;
    logic            misp;
    logic            misal;
    logic            illegal;
    longint          sb;
    longint          sm;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [XLEN-1:0] lk_pc = '0;
  logic            lk_pred_taken;
  logic [CNT_W-1:0] stat_branches, stat_mispredicts;

  branch_resolve_unit_if #(.XLEN(XLEN)) bus ();

  branch_resolve_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .lk_pc(lk_pc), .lk_pred_taken(lk_pred_taken),
    .bus(bus), .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     failures = 0;
  exp_t   sb_q[$];
  int     hist_m[DEPTH];
  longint sb_m = 0;
  longint sm_m = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic int idx_of(input logic [XLEN-1:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) hist_m[i] = 1;
    sb_m = 0;
    sm_m = 0;
  endtask

  // One request per call: drive at negedge, check the lookup, predict the result.
  task automatic issue(input logic v, input logic br, input logic jal, input logic jalr,
                       input logic [2:0] f3, input logic [XLEN-1:0] pc,
                       input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                       input logic [XLEN-1:0] imm, input logic pred, input logic fl,
                       input logic [XLEN-1:0] lk);
    exp_t e;
    logic cond, legal_br;
    int   i;
    @(negedge clk);
    bus.in_valid = v; bus.in_branch = br; bus.in_jal = jal; bus.in_jalr = jalr;
    bus.in_funct3 = f3; bus.in_pc = pc; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
    bus.in_imm = imm; bus.in_pred_taken = pred; bus.flush = fl;
    lk_pc = lk;
    #1;
    check("lookup", lk_pred_taken, hist_m[idx_of(lk)] >= 2);
    if (v && !fl) begin
      legal_br = br && !(f3 == 3'b010 || f3 == 3'b011);
      case (f3)
        3'd0: cond = rs1 == rs2;
        3'd1: cond = rs1 != rs2;
        3'd4: cond = $signed(rs1) < $signed(rs2);
        3'd5: cond = $signed(rs1) >= $signed(rs2);
        3'd6: cond = rs1 < rs2;
        3'd7: cond = rs1 >= rs2;
        default: cond = 1'b0;
      endcase
      e.taken   = jal || jalr || (legal_br && cond);
      e.target  = jalr ? ((rs1 + imm) & ~64'd1) : (pc + imm);
      e.link    = pc + 64'd4;
      e.illegal = br && !legal_br;
      e.misp    = (br || jal || jalr) ? (e.taken != pred) : 1'b0;
      e.misal   = e.taken && e.target[1];
      if (legal_br || jal || jalr) begin
        if (sb_m < CMAX) sb_m++;
        if (e.misp && sm_m < CMAX) sm_m++;
      end
      e.sb = sb_m;
      e.sm = sm_m;
      if (legal_br) begin
        i = idx_of(pc);
        hist_m[i] = cond ? ((hist_m[i] < 3) ? hist_m[i] + 1 : 3)
                         : ((hist_m[i] > 0) ? hist_m[i] - 1 : 0);
      end
      sb_q.push_back(e);
    end
  endtask

  task automatic idle();
    issue(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, '0, '0, '0, '0, 1'b0, 1'b0, lk_pc);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, bus.res_valid, 0);
    check({tag, "_taken"}, bus.res_taken, 0);
    check({tag, "_target"}, bus.res_target, 0);
    check({tag, "_link"}, bus.res_link, 0);
    check({tag, "_misp"}, bus.res_mispredict, 0);
    check({tag, "_misal"}, bus.res_misaligned, 0);
    check({tag, "_illegal"}, bus.res_illegal, 0);
    check({tag, "_stat_br"}, stat_branches, 0);
    check({tag, "_stat_mp"}, stat_mispredicts, 0);
  endtask

  // Monitor: every res_valid pulse must match the oldest queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.res_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("res_taken", bus.res_taken, e.taken);
          check("res_target", bus.res_target, e.target);
          check("res_link", bus.res_link, e.link);
          check("res_mispredict", bus.res_mispredict, e.misp);
          check("res_misaligned", bus.res_misaligned, e.misal);
          check("res_illegal", bus.res_illegal, e.illegal);
          check("stat_branches", stat_branches, e.sb);
          check("stat_mispredicts", stat_mispredicts, e.sm);
        end
      end
    end
  end

  initial begin
    logic [XLEN-1:0] pc, rs1, rs2, imm;
    logic [2:0]      f3;
    int              kind;

    bus.in_valid = 0; bus.in_branch = 0; bus.in_jal = 0; bus.in_jalr = 0;
    bus.in_funct3 = 0; bus.in_pc = 0; bus.in_rs1 = 0; bus.in_rs2 = 0;
    bus.in_imm = 0; bus.in_pred_taken = 0; bus.flush = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) issue(0, 0, 0, 0, 0, '0, '0, '0, '0, 0, 0, 64'(i * 52));

    // BEQ taken with a not-taken prediction.
    issue(1, 1, 0, 0, 3'b000, 64'h100, 64'd5, 64'd5, 64'h20, 0, 0, 64'h100);
    issue(1, 1, 0, 0, 3'b100, 64'h200, '1, 64'd1, 64'h8, 1, 0, 64'h200);
    issue(1, 1, 0, 0, 3'b110, 64'h204, '1, 64'd1, 64'h8, 0, 0, 64'h204);
    issue(1, 1, 0, 0, 3'b111, 64'h208, 64'd77, 64'd77, -64'sd16, 1, 0, 64'h208);

    // Saturate the entry for 0x40, including a same-cycle lookup collision.
    for (int i = 0; i < 3; i++)
      issue(1, 1, 0, 0, 3'b001, 64'h40, 64'd1, 64'd2, 64'h10, 1, 0, 64'h40);
    issue(0, 0, 0, 0, 0, '0, '0, '0, '0, 0, 0, 64'h40);
    issue(0, 0, 0, 0, 0, '0, '0, '0, '0, 0, 0, 64'h40 + 4 * DEPTH);

    issue(1, 0, 0, 1, 3'b000, 64'h300, 64'h1001, 64'd0, 64'd2, 1, 0, 64'h300);
    issue(1, 0, 1, 0, 3'b000, 64'hFFFF_FFFF_FFFF_FFFC, '0, '0, 64'h8, 0, 0, 64'h0);

    issue(1, 1, 0, 0, 3'b000, 64'h500, 64'd3, 64'd3, 64'h4, 0, 1, 64'h500);
    @(negedge clk);
    check("flush_no_valid", bus.res_valid, 0);
    issue(1, 1, 0, 0, 3'b010, 64'h504, 64'd3, 64'd3, 64'h4, 1, 0, 64'h504);
    issue(1, 0, 0, 0, 3'b000, 64'h508, 64'd3, 64'd3, 64'h4, 1, 0, 64'h508);

    // Random traffic, long enough to drive both statistics into saturation.
    for (int n = 0; n < 400; n++) begin
      kind = int'($urandom_range(0, 9));
      f3   = 3'($urandom_range(0, 7));
      pc   = 64'($urandom_range(0, 8 * DEPTH - 1)) << 2;
      if ($urandom_range(0, 3) == 0) pc = {$urandom, $urandom};
      rs1  = {$urandom, $urandom};
      rs2  = ($urandom_range(0, 3) == 0) ? rs1 : {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) begin
        rs1 = 64'($signed($urandom_range(0, 8)) - 4);
        rs2 = 64'($signed($urandom_range(0, 8)) - 4);
      end
      imm  = 64'($signed($urandom_range(0, 4095)) - 2048);
      issue($urandom_range(0, 6) != 0, kind < 7, kind == 7, kind == 8, f3, pc, rs1, rs2, imm,
            ($urandom_range(0, 1) == 0) ? (hist_m[idx_of(pc)] >= 2) : 1'($urandom),
            $urandom_range(0, 9) == 0, 64'($urandom_range(0, 8 * DEPTH - 1)) << 2);
    end
    check("stat_branches_saturated", stat_branches, CMAX);

    // Reset coinciding with a valid request: the request is lost.
    @(negedge clk);
    bus.in_valid = 1; bus.in_branch = 1; bus.in_funct3 = 3'b000; bus.flush = 0;
    rst_n = 1'b0;
    @(negedge clk);
    check_zero_outputs("midreset");
    model_reset();
    rst_n = 1'b1;
    bus.in_valid = 0;
    for (int i = 0; i < DEPTH; i++) issue(0, 0, 0, 0, 0, '0, '0, '0, '0, 0, 0, 64'(i * 4));
    issue(1, 1, 0, 0, 3'b000, 64'h40, 64'd9, 64'd9, 64'h4, 0, 0, 64'h40);
    issue(0, 0, 0, 0, 0, '0, '0, '0, '0, 0, 0, 64'h40);

    repeat (3) idle();
    check("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
